// File: rtl/seq_chunk_addsub.sv
// rtl/seq_chunk_addsub.sv - chunk-serial add/sub with registered carry (optional saturation: ADDSUB_SAT_EN)
module seq_chunk_addsub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             Z
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = $clog2(NCH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             accept;
    logic [CHUNK:0]   slice;
    logic             c_msb;
    logic             ovf;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] s_final;
`ifdef ADDSUB_SAT_EN
    logic             a_msb;
`endif

    assign last   = (cnt == CW'(NCH - 1));
    assign accept = (state == IDLE) && Start;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Busy decode
    always_comb begin
        next_state = state;
        Busy       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // One ripple slice over the low chunk; carry into the chunk MSB recovered from sum^a^b
    always_comb begin
        slice    = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
        c_msb    = a_reg[CHUNK-1] ^ b_reg[CHUNK-1] ^ slice[CHUNK-1];
        ovf      = c_msb ^ slice[CHUNK];
        res_next = (res >> CHUNK) | (WIDTH'(slice[CHUNK-1:0]) << (WIDTH - CHUNK));
`ifdef ADDSUB_SAT_EN
        if (ovf) begin
            s_final = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            s_final = res_next;
        end
`else
        s_final = res_next;
`endif
    end

    // Operand latch, chunk shifting, and result/flag registration on the final chunk
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            Done  <= 1'b0;
            S     <= '0;
            Cout  <= 1'b0;
            V     <= 1'b0;
            Z     <= 1'b0;
`ifdef ADDSUB_SAT_EN
            a_msb <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            if (accept) begin
                a_reg <= A;
                b_reg <= B ^ {WIDTH{Sub}};
                carry <= Sub ? 1'b1 : Cin;
                cnt   <= '0;
                res   <= '0;
`ifdef ADDSUB_SAT_EN
                a_msb <= A[WIDTH-1];
`endif
            end else if (state == RUN) begin
                a_reg <= a_reg >> CHUNK;
                b_reg <= b_reg >> CHUNK;
                carry <= slice[CHUNK];
                cnt   <= cnt + 1'b1;
                res   <= res_next;
                if (last) begin
                    S    <= s_final;
                    Cout <= slice[CHUNK];
                    V    <= ovf;
                    Z    <= (s_final == '0);
                    Done <= 1'b1;
                end
            end
        end
    end

endmodule
